// File: rtl/operand_fetch.sv
// operand_fetch: register file, operand read with writeback bypass, and a
// distance-1 read-after-write interlock in front of the execute stage.
// Optional feature: define OF_ZERO_REG_EN to hard-wire register 0 to zero
// (writes to it are dropped and it never causes a hazard stall).
module operand_fetch #(
    parameter int ADDR   = 16,
    parameter int W_IMM  = 16,
    parameter int W_OPR  = 32,
    parameter int W_RD   = 5,
    parameter int D_INFO = 16,
    parameter int WRSV   = 0
) (
    input  logic              clk,
    input  logic              reset,
    // decoded instruction from upstream
    input  logic              v_i,
    output logic              stall_o,
    input  logic [ADDR-1:0]   pc_i,
    input  logic [W_IMM-1:0]  imm_i,
    input  logic [D_INFO-1:0] d_info_i,
    input  logic [W_RD-1:0]   rs0_i,
    input  logic [W_RD-1:0]   rs1_i,
    input  logic              use0_i,
    input  logic              use1_i,
    input  logic [W_RD-1:0]   rd_i,
    input  logic              flush_i,
    // towards execute
    output logic              v_o,
    input  logic              stall_i,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic [D_INFO-1:0] d_info_o,
    output logic [W_RD-1:0]   wb_r_o,
    output logic [W_OPR-1:0]  opr0_o,
    output logic [W_OPR-1:0]  opr1_o,
    // register write port, driven by execute
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_r_i,
    input  logic [W_OPR-1:0]  wb_data_i
);

    localparam int DEPTH = 1 << W_RD;

    logic [W_OPR-1:0] regs [DEPTH];
    logic             v_r;
    logic             wr_en;
    logic             use0_eff;
    logic             use1_eff;
    logic             advance;
    logic             hazard;
    logic [W_OPR-1:0] rd0_data;
    logic [W_OPR-1:0] rd1_data;

`ifdef OF_ZERO_REG_EN
    // Register 0 is never written, so its reset value of zero is what every
    // read returns; it is also never a real dependency.
    assign wr_en    = wb_i && (wb_r_i != '0);
    assign use0_eff = use0_i && (rs0_i != '0);
    assign use1_eff = use1_i && (rs1_i != '0);
`else
    assign wr_en    = wb_i;
    assign use0_eff = use0_i;
    assign use1_eff = use1_i;
`endif

    // The bypass makes a same-cycle write visible to the read, which is also
    // how a dependent instruction picks up its producer's result after the
    // one-cycle bubble.
    assign rd0_data = (wr_en && (rs0_i == wb_r_i)) ? wb_data_i : regs[rs0_i];
    assign rd1_data = (wr_en && (rs1_i == wb_r_i)) ? wb_data_i : regs[rs1_i];

    // An empty output register never blocks, even if execute is stalled.
    assign advance = ~stall_i | ~v_r;

    // The instruction sitting in execute only produces its result next cycle,
    // so a consumer at distance 1 must wait exactly one bubble.
    assign hazard = v_i & v_r & d_info_o[WRSV] &
                    ((use0_eff & (rs0_i == wb_r_o)) |
                     (use1_eff & (rs1_i == wb_r_o)));

    // A flushed instruction is dropped upstream, so it never needs holding.
    assign stall_o = ~advance | (hazard & ~flush_i);
    assign v_o     = v_r;

    // Register file write port; the whole file clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_r_i] <= wb_data_i;
        end
    end

    // Output register: flush beats hazard beats normal capture, all gated by advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r      <= 1'b0;
            pc_o     <= '0;
            imm_o    <= '0;
            d_info_o <= '0;
            wb_r_o   <= '0;
            opr0_o   <= '0;
            opr1_o   <= '0;
        end else if (advance) begin
            if (flush_i || hazard) begin
                v_r <= 1'b0;
            end else begin
                v_r      <= v_i;
                pc_o     <= pc_i;
                imm_o    <= imm_i;
                d_info_o <= d_info_i;
                wb_r_o   <= rd_i;
                opr0_o   <= rd0_data;
                opr1_o   <= rd1_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized run, all checked
// against a behavioural model of the register file and the stage's output.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i, stall_o, use0_i, use1_i, flush_i, v_o, stall_i, wb_i;
    logic [15:0] pc_i, imm_i, d_info_i, pc_o, imm_o, d_info_o;
    logic [4:0]  rs0_i, rs1_i, rd_i, wb_r_o, wb_r_i;
    logic [31:0] opr0_o, opr1_o, wb_data_i;

    int vectors    = 0;
    int miscompares = 0;

    // behavioural model: register contents and the instruction held for execute
    logic [31:0] m_rf [32];
    logic        m_v;
    logic [15:0] m_pc, m_imm, m_dinfo;
    logic [4:0]  m_wbr;
    logic [31:0] m_op0, m_op1;

    operand_fetch dut (
        .clk(clk), .reset(reset),
        .v_i(v_i), .stall_o(stall_o), .pc_i(pc_i), .imm_i(imm_i),
        .d_info_i(d_info_i), .rs0_i(rs0_i), .rs1_i(rs1_i),
        .use0_i(use0_i), .use1_i(use1_i), .rd_i(rd_i), .flush_i(flush_i),
        .v_o(v_o), .stall_i(stall_i), .pc_o(pc_o), .imm_o(imm_o),
        .d_info_o(d_info_o), .wb_r_o(wb_r_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_real(input logic [4:0] idx);
`ifdef OF_ZERO_REG_EN
        return idx != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    // newest value of a register as seen this cycle (pending write included)
    function automatic logic [31:0] m_read(input logic [4:0] idx);
`ifdef OF_ZERO_REG_EN
        if (idx == 5'd0) return 32'd0;
`endif
        if (wb_i && wb_r_i == idx) return wb_data_i;
        return m_rf[idx];
    endfunction

    // consumer at the input needs a register the instruction in execute has not produced yet
    function automatic bit m_hazard();
        bit dep0, dep1;
        dep0 = use0_i && m_is_real(rs0_i) && rs0_i == m_wbr;
        dep1 = use1_i && m_is_real(rs1_i) && rs1_i == m_wbr;
        return v_i && m_v && m_dinfo[0] && (dep0 || dep1);
    endfunction

    function automatic bit m_stall();
        return (stall_i && m_v) || (m_hazard() && !flush_i);
    endfunction

    function automatic logic [116:0] m_fields();
        return {m_pc, m_imm, m_dinfo, m_wbr, m_op0, m_op1};
    endfunction

    function automatic logic [116:0] dut_fields();
        return {pc_o, imm_o, d_info_o, wb_r_o, opr0_o, opr1_o};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_v = 1'b0; m_pc = '0; m_imm = '0; m_dinfo = '0; m_wbr = '0; m_op0 = '0; m_op1 = '0;
    endtask

    task automatic clear_inputs();
        v_i = 0; pc_i = 0; imm_i = 0; d_info_i = 0; rs0_i = 0; rs1_i = 0;
        use0_i = 0; use1_i = 0; rd_i = 0; flush_i = 0; stall_i = 0;
        wb_i = 0; wb_r_i = 0; wb_data_i = 0;
    endtask

    task automatic set_instr(input logic [15:0] pc, input logic [4:0] rs0, input logic u0,
                             input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                             input logic [15:0] dinfo);
        v_i = 1; pc_i = pc; imm_i = 16'($urandom); d_info_i = dinfo;
        rs0_i = rs0; use0_i = u0; rs1_i = rs1; use1_i = u1; rd_i = rd; flush_i = 0;
    endtask

    // one clock edge: the model advances from the inputs present before the edge
    task automatic applyStimulus();
        bit adv, hz;
        logic [31:0] r0, r1;
        adv = !(stall_i && m_v);
        hz  = m_hazard();
        r0  = m_read(rs0_i);
        r1  = m_read(rs1_i);
        @(posedge clk);
        if (wb_i && m_is_real(wb_r_i)) m_rf[wb_r_i] = wb_data_i;
        if (adv) begin
            if (flush_i || hz) begin
                m_v = 1'b0;
            end else begin
                m_v = v_i; m_pc = pc_i; m_imm = imm_i; m_dinfo = d_info_i;
                m_wbr = rd_i; m_op0 = r0; m_op1 = r1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        vectors++;
        if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_v_o: got %0b want 0", v_o); end
        vectors++;
        if (dut_fields() !== 117'd0) begin miscompares++; $display("[TB] FAIL reset_fields: got %h want 0", dut_fields()); end
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall_o: got %0b want 0", stall_o); end
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        clear_inputs();
        wb_i = 1; wb_r_i = 5'd3; wb_data_i = 32'h12345678;
        applyStimulus();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0100, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 16'h0000);
        applyStimulus();
        clear_inputs();
        vectors++;
        if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL write_read_v_o: got %0b want 1", v_o); end
        vectors++;
        if (opr0_o !== 32'h12345678) begin miscompares++; $display("[TB] FAIL write_read_opr0: got %h want 12345678", opr0_o); end
        vectors++;
        if (pc_o !== 16'h0100) begin miscompares++; $display("[TB] FAIL write_read_pc: got %h want 0100", pc_o); end
    endtask

    task automatic test_bypass();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0200, 5'd7, 1'b1, 5'd0, 1'b0, 5'd2, 16'h0000);
        wb_i = 1; wb_r_i = 5'd7; wb_data_i = 32'h0000DEAD;
        applyStimulus();
        clear_inputs();
        vectors++;
        if (opr0_o !== 32'h0000DEAD) begin miscompares++; $display("[TB] FAIL bypass_opr0: got %h want 0000dead", opr0_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        clear_inputs();
        applyStimulus();
        set_instr(16'h0300, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 16'h0001);
        applyStimulus();
        set_instr(16'h0304, 5'd0, 1'b0, 5'd5, 1'b1, 5'd12, 16'h0000);
        #1;
        vectors++;
        if (stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_stall_hazard: got %0b want 1", stall_o); end
        applyStimulus();
        vectors++;
        if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_bubble_v_o: got %0b want 0", v_o); end
        wb_i = 1; wb_r_i = 5'd5; wb_data_i = d;
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stall_release: got %0b want 0", stall_o); end
        applyStimulus();
        clear_inputs();
        vectors++;
        if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_issue_v_o: got %0b want 1", v_o); end
        vectors++;
        if (opr1_o !== d) begin miscompares++; $display("[TB] FAIL b2b_opr1: got %h want %h", opr1_o, d); end
        vectors++;
        if (pc_o !== 16'h0304 || wb_r_o !== 5'd12) begin
            miscompares++; $display("[TB] FAIL b2b_fields: got pc %h rd %0d want pc 0304 rd 12", pc_o, wb_r_o);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0400, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 16'h0000);
        applyStimulus();
        stall_i = 1;
        for (int c = 0; c < 3; c++) begin
            set_instr(16'($urandom), 5'd6, 1'b1, 5'd6, 1'b1, 5'($urandom), 16'($urandom));
            #1;
            vectors++;
            if (stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_hold_stall_o[%0d]: got %0b want 1", c, stall_o); end
            applyStimulus();
            vectors++;
            if (v_o !== 1'b1 || pc_o !== 16'h0400 || wb_r_o !== 5'd6) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_out[%0d]: got v %0b pc %h rd %0d want v 1 pc 0400 rd 6", c, v_o, pc_o, wb_r_o);
            end
        end
        stall_i = 0;
        set_instr(16'h0408, 5'd3, 1'b1, 5'd4, 1'b0, 5'd8, 16'h0000);
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release_stall_o: got %0b want 0", stall_o); end
        applyStimulus();
        clear_inputs();
        vectors++;
        if (v_o !== 1'b1 || pc_o !== 16'h0408) begin
            miscompares++; $display("[TB] FAIL stall_release_capture: got v %0b pc %h want v 1 pc 0408", v_o, pc_o);
        end
    endtask

    task automatic test_flush_hazard();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0500, 5'd1, 1'b0, 5'd1, 1'b0, 5'd4, 16'h0001);
        applyStimulus();
        set_instr(16'h0504, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 16'h0000);
        flush_i = 1;
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_stall_o: got %0b want 0", stall_o); end
        applyStimulus();
        clear_inputs();
        vectors++;
        if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_v_o: got %0b want 0", v_o); end
    endtask

    task automatic test_zero_reg();
        logic [31:0] want;
`ifdef OF_ZERO_REG_EN
        want = 32'd0;
`else
        want = 32'h0000FFFF;
`endif
        clear_inputs();
        wb_i = 1; wb_r_i = 5'd0; wb_data_i = 32'h0000FFFF;
        applyStimulus();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0600, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 16'h0000);
        applyStimulus();
        clear_inputs();
        vectors++;
        if (opr0_o !== want || opr1_o !== want) begin
            miscompares++; $display("[TB] FAIL zero_reg: got %h/%h want %h", opr0_o, opr1_o, want);
        end
    endtask

    task automatic test_reset_under_stall();
        clear_inputs();
        applyStimulus();
        set_instr(16'h0700, 5'd1, 1'b0, 5'd1, 1'b0, 5'd3, 16'h0001);
        applyStimulus();
        stall_i = 1; v_i = 0;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (v_o !== 1'b0 || dut_fields() !== 117'd0) begin
            miscompares++; $display("[TB] FAIL async_reset: got v %0b fields %h want 0", v_o, dut_fields());
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        set_instr(16'h0704, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 16'h0000);
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_stall_o: got %0b want 0", stall_o); end
        applyStimulus();
        clear_inputs();
        vectors++;
        if (v_o !== 1'b1 || pc_o !== 16'h0704 || opr0_o !== 32'd0) begin
            miscompares++; $display("[TB] FAIL post_reset_issue: got v %0b pc %h opr0 %h want v 1 pc 0704 opr0 0", v_o, pc_o, opr0_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            v_i       = ($urandom_range(0, 3) != 0);
            pc_i      = 16'($urandom);
            imm_i     = 16'($urandom);
            d_info_i  = 16'($urandom);
            rs0_i     = 5'($urandom_range(0, 7));
            rs1_i     = 5'($urandom_range(0, 7));
            use0_i    = 1'($urandom);
            use1_i    = 1'($urandom);
            rd_i      = 5'($urandom_range(0, 7));
            flush_i   = ($urandom_range(0, 9) == 0);
            stall_i   = ($urandom_range(0, 3) == 0);
            wb_i      = 1'($urandom);
            wb_r_i    = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            #1;
            vectors++;
            if (stall_o !== m_stall()) begin
                miscompares++; $display("[TB] FAIL rand_stall_o[%0d]: got %0b want %0b", n, stall_o, m_stall());
            end
            applyStimulus();
            vectors++;
            if (v_o !== m_v) begin
                miscompares++; $display("[TB] FAIL rand_v_o[%0d]: got %0b want %0b", n, v_o, m_v);
            end
            vectors++;
            if (dut_fields() !== m_fields()) begin
                miscompares++; $display("[TB] FAIL rand_fields[%0d]: got %h want %h", n, dut_fields(), m_fields());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_flush_hazard();
        test_zero_reg();
        test_reset_under_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Pipeline stage directly upstream of the execute stage. It holds the general-purpose register file, reads the two source operands of each decoded instruction, bypasses the same-cycle writeback value, and interlocks on a distance-1 read-after-write hazard. It drives the execute stage's `v/pc/imm/opr0/opr1/d_info/wb_r` inputs and accepts that stage's `result/wb_r/wb` outputs as its register write port.

## Interface
- `ADDR`, 16: PC width.
- `W_IMM`, 16: immediate width.
- `W_OPR`, 32: operand and register width.
- `W_RD`, 5: register index width; the file has 2^W_RD entries.
- `D_INFO`, 16: decode-info width. The block passes this field through opaquely, except bit `WRSV`.
- `WRSV`, 0: index of the register-write-enable bit within `d_info`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `v_i`  in  1  decoded instruction valid.
- `stall_o`  out  1  upstream must hold its inputs.
- `pc_i`  in  ADDR  instruction PC.
- `imm_i`  in  W_IMM  immediate.
- `d_info_i`  in  D_INFO  decode info.
- `rs0_i`, `rs1_i`  in  W_RD  source register indices.
- `use0_i`, `use1_i`  in  1  source actually read; used for the hazard check only.
- `rd_i`  in  W_RD  destination index.
- `flush_i`  in  1  taken branch; kill the instruction at the input.
- `v_o`  out  1  output valid.
- `stall_i`  in  1  execute-stage stall.
- `pc_o`, `imm_o`, `d_info_o`, `wb_r_o`  out  ADDR/W_IMM/D_INFO/W_RD  registered pass-through.
- `opr0_o`, `opr1_o`  out  W_OPR  registered operands.
- `wb_i`  in  1  register write enable, from execute `wb_o`.
- `wb_r_i`  in  W_RD  write index.
- `wb_data_i`  in  W_OPR  write data.

## Operation
- Register file: 2^W_RD × W_OPR. Writes occur on the clock edge when `wb_i`=1. Reads are combinational.
- Bypass: when a read index equals `wb_r_i` and `wb_i`=1, the read returns `wb_data_i`.
- Output register: holds `v_r` and all `*_o` fields.
- `advance = ~stall_i | ~v_r`.
- `hazard = v_i & v_r & d_info_o[WRSV] & ((use0_i & rs0_i==wb_r_o) | (use1_i & rs1_i==wb_r_o))`.
  - The instruction now in execute writes its result one cycle later. That result arrives through the bypass, so exactly one bubble is needed.
- On a clock edge with `advance`=1, priority is:
  1. `flush_i`: `v_r`←0.
  2. `hazard`: `v_r`←0 (bubble inserted).
  3. Otherwise: `v_r`←`v_i`, and capture pc, imm, d_info, `rd_i`→`wb_r_o`, and the bypassed operand reads.
- On a clock edge with `advance`=0, the output register holds all fields.
- `stall_o = ~advance | (hazard & ~flush_i)`.
- A flushed instruction is dropped. Upstream discards it in the same cycle.
- `opr0_o`/`opr1_o` are captured even when the corresponding `use` bit is 0.

## Timing
- Reset (`reset`=0, asynchronous):
  - `v_o`=0 and every `*_o` field is 0.
  - All registers in the file are 0.
- Latency is one cycle from accepted input to `v_o`.
- With no stalls, one instruction is accepted per cycle.
- A RAW hazard at distance 1 costs exactly one cycle. The dependent instruction issues in the cycle after the producer leaves execute, with the value taken from the bypass.
- At distance 2 or more there is no stall: the value comes from the bypass or from the file.
- Simultaneous write and read of the same index: the read returns the new data.
- If reset is asserted while `stall_i` is held, state clears immediately. After reset releases, `v_o` is 0, so the stage accepts input regardless of `stall_i`.
- `stall_i` while `v_r`=0 does not block. The bubble is overwritten.

## Configuration
- `OF_ZERO_REG_EN` defined:
  - Register 0 always reads 0, and writes to it are ignored (the bypass included).
  - The hazard check ignores source index 0.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset, then write r3=0x12345678 via `wb_i`. Two cycles later issue `rs0_i`=3 -> `opr0_o`=0x12345678, and `v_o`=1 one cycle after issue.
- Back-to-back: A with `rd`=5 and WRSV=1, then B with `use1_i`=1 and `rs1_i`=5 -> `stall_o`=1 for one cycle and a bubble (`v_o`=0). B issues next, with `opr1_o` equal to the `wb_data_i` presented with `wb_r_i`=5.
- `wb_i`=1, `wb_r_i`=7, `wb_data_i`=0xDEAD in the same cycle as an accepted read of r7 -> `opr0_o`=0xDEAD.
- `stall_i`=1 with `v_o`=1 for 3 cycles -> outputs constant and `stall_o`=1. Release -> the next instruction is captured.
- `flush_i`=1 while a hazard is present -> `v_o`=0 next cycle and `stall_o`=0.
- With `OF_ZERO_REG_EN`: write r0=0xFFFF, read r0 -> 0. Without the macro -> 0xFFFF.
